// File: rtl/sram_bram_resp.sv
// Block-RAM responder for the sram_req/sram_ready interface.
// Clears its memory after every reset, then serves 16-bit reads and byte-masked writes.
module sram_bram_resp #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        sram_req,
    output logic        sram_ready,
    input  logic        sram_rd,
    input  logic [17:0] sram_addr,
    input  logic [1:0]  sram_be,
    input  logic [15:0] sram_wr_data,
    output logic        sram_rd_data_vld,
    output logic [15:0] sram_rd_data,
    output logic        init_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              clr_we_c;
    logic              accept_c;

    logic [15:0]       mem [DEPTH];
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [1:0]        wr_be_c;
    logic [15:0]       wr_data_c;
    logic [15:0]       rd_word;
    logic              rd_pend;

    // Upper address bits alias onto the implemented depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^sram_addr[17:ADDR_W];

    assign accept_c = sram_req && sram_ready;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        clr_we_c  = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we_c = 1'b1;
                ptr_nxt  = ptr + ADDR_W'(1);
                if (&ptr) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept_c && (WAIT_CYCLES != 0)) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_W'(WAIT_CYCLES);
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
                else                  cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    // Ready is registered from the next state so it never follows sram_req combinationally.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            cnt        <= '0;
            sram_ready <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            sram_ready <= (state_nxt == ST_IDLE);
            if ((state == ST_CLEAR) && (&ptr)) init_done <= 1'b1;
        end
    end

    // Clear sequence and initiator writes share the single BRAM write port.
    assign wr_en_c   = reset_ && (clr_we_c || (accept_c && !sram_rd));
    assign wr_addr_c = clr_we_c ? ptr : sram_addr[ADDR_W-1:0];
    assign wr_be_c   = clr_we_c ? 2'b11 : sram_be;
    assign wr_data_c = clr_we_c ? 16'h0000 : sram_wr_data;

    always_ff @(posedge clk) begin
        if (wr_en_c && wr_be_c[0]) mem[wr_addr_c][7:0]  <= wr_data_c[7:0];
        if (wr_en_c && wr_be_c[1]) mem[wr_addr_c][15:8] <= wr_data_c[15:8];
        rd_word <= mem[sram_addr[ADDR_W-1:0]];
    end

    // Two-stage read return: BRAM output register, then the held output word.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            rd_pend          <= 1'b0;
            sram_rd_data_vld <= 1'b0;
            sram_rd_data     <= 16'h0000;
        end else begin
            rd_pend          <= accept_c && sram_rd;
            sram_rd_data_vld <= rd_pend;
            if (rd_pend) sram_rd_data <= rd_word;
        end
    end

endmodule
